// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial-detector sequencer: FSM state codes and default word width.
package seq_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t CLEAR  = 3'd1;
    localparam state_t STREAM = 3'd2;
    localparam state_t DRAIN  = 3'd3;
    localparam state_t DONE   = 3'd4;

endpackage

// File: rtl/seq_detect_sequencer_if.sv
// Command/status bundle between the switch/key front end (master) and the sequencer (slave).
interface seq_detect_sequencer_if
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
);

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;

    modport master (
        output start, abort, data_in,
        input  busy, done, match_count
    );

    modport slave (
        input  start, abort, data_in,
        output busy, done, match_count
    );

endinterface

// File: rtl/piso_shift.sv
// Parallel-in serial-out register: loads a word and shifts it left, presenting the MSB.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             msb
);

    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] shreg_next;

    // Each bit takes the load value, its lower neighbour on a shift, or holds.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi == 0) begin : g_lsb
            assign shreg_next[gi] = load ? data[gi] : (shift ? 1'b0 : shreg_reg[gi]);
        end else begin : g_upper
            assign shreg_next[gi] = load ? data[gi] : (shift ? shreg_reg[gi-1] : shreg_reg[gi]);
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            shreg_reg <= '0;
        end else begin
            shreg_reg <= shreg_next;
        end
    end

    assign msb = shreg_reg[WIDTH-1];

endmodule

// File: rtl/seq_detect_sequencer.sv
// Clears the external 1101/1111 detector, streams a word into it MSB-first and counts
// the cycles in which its Moore output is high, reporting the total with a done pulse.
module seq_detect_sequencer
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    seq_detect_sequencer_if.slave  bus,
    input  logic                   det_z,
    output logic                   det_resetn,
    output logic                   w_out
);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [CNT_W-1:0] match_count_reg;
    logic             bit_pending_reg;
    logic             load;
    logic             shift;
    logic             last_bit;
    logic             shreg_msb;

    assign load     = (state_reg == IDLE) && bus.start;
    assign shift    = (state_reg == STREAM);
    assign last_bit = (bit_cnt_reg == CNT_W'(WIDTH - 1));

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .Clock  (Clock),
        .Resetn (Resetn),
        .load   (load),
        .shift  (shift),
        .data   (bus.data_in),
        .msb    (shreg_msb)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if ((state_reg != IDLE) && bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = CLEAR;
                CLEAR:   state_next = STREAM;
                STREAM:  if (last_bit) state_next = DRAIN;
                DRAIN:   state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        det_resetn = (state_reg != CLEAR);
        w_out      = (state_reg == STREAM) ? shreg_msb : 1'b0;
        bus.busy   = (state_reg != IDLE);
        bus.done   = (state_reg == DONE);
    end

    // The detector answers one cycle after each bit, so a bit presented in STREAM
    // arms the counter for the following edge; an abort must not arm it.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            bit_cnt_reg     <= '0;
            bit_pending_reg <= 1'b0;
            match_count_reg <= '0;
        end else begin
            bit_cnt_reg     <= (shift && !last_bit) ? bit_cnt_reg + 1'b1 : '0;
            bit_pending_reg <= shift && !bus.abort;
            if (load) begin
                match_count_reg <= '0;
            end else if (bit_pending_reg && det_z && (match_count_reg != CNT_W'(WIDTH))) begin
                match_count_reg <= match_count_reg + 1'b1;
            end
        end
    end

    assign bus.match_count = match_count_reg;

endmodule

// File: tb/tb_seq_detect_sequencer.sv
// Bench for the sequencer with a behavioural 1101/1111 Moore detector on its serial side.
module tb_seq_detect_sequencer;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       det_z = 1'b0;
    logic       det_resetn;
    logic       w_out;
    logic [3:0] det_hist = 4'd0;
    int         det_n = 0;
    int         total = 0;
    int         bad = 0;

    always #5 Clock = ~Clock;

    seq_detect_sequencer_if #(.WIDTH(8)) bus ();

    seq_detect_sequencer #(.WIDTH(8)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .bus        (bus),
        .det_z      (det_z),
        .det_resetn (det_resetn),
        .w_out      (w_out)
    );

    // Overlapping detector: z is high the cycle after the last four bits read 1101 or 1111.
    always @(posedge Clock) begin
        if (!det_resetn) begin
            det_hist <= 4'd0;
            det_n    <= 0;
            det_z    <= 1'b0;
        end else begin
            det_hist <= {det_hist[2:0], w_out};
            det_n    <= (det_n < 4) ? det_n + 1 : 4;
            det_z    <= (det_n >= 3) &&
                        (({det_hist[2:0], w_out} == 4'b1101) || ({det_hist[2:0], w_out} == 4'b1111));
        end
    end

    // Reference: number of 4-bit windows ending at bit positions 3..nbits-1 (MSB-first)
    // of the word that equal a detector pattern.
    function automatic int exp_hits(input logic [7:0] d, input int nbits);
        int n = 0;
        for (int k = 3; k < nbits; k++) begin
            logic [7:0] sh;
            sh = d >> (7 - k);
            if (sh[3:0] == 4'b1101 || sh[3:0] == 4'b1111) n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One full run; cycle c is the cycle after the c-th edge counted from the start edge.
    task automatic run_word(input logic [7:0] d, input bit hold,
                            output int cnt, output int done_at, output int done_n,
                            output int busy_n, output int dr_low, output int w_err);
        cnt = -1; done_at = -1; done_n = 0; busy_n = 0; dr_low = 0; w_err = 0;
        bus.start   = 1'b1;
        bus.data_in = d;
        tick();
        if (!hold) bus.start = 1'b0;
        bus.data_in = 8'($urandom);
        for (int c = 1; c <= 20; c++) begin
            logic exp_w;
            if (hold && c == 12) bus.start = 1'b0;
            busy_n += int'(bus.busy);
            done_n += int'(bus.done);
            dr_low += int'(!det_resetn);
            if (bus.done) begin
                done_at = c;
                cnt     = int'(bus.match_count);
            end
            exp_w = (c >= 2 && c <= 9) ? d[9 - c] : 1'b0;
            if (w_out !== exp_w) w_err++;
            tick();
        end
        $display("run data=%02h hold=%0d count=%0d done_at=%0d busy=%0d", d, hold, cnt, done_at, busy_n);
    endtask

    task automatic full_check(input string tag, input logic [7:0] d, input bit hold, input int exp_count);
        int cnt, done_at, done_n, busy_n, dr_low, w_err;
        run_word(d, hold, cnt, done_at, done_n, busy_n, dr_low, w_err);
        check({tag, " count"}, cnt, exp_count);
        check({tag, " done_cycle"}, done_at, 11);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " busy_cycles"}, busy_n, 11);
        check({tag, " det_resetn_low"}, dr_low, 1);
        check({tag, " w_out_errors"}, w_err, 0);
        check({tag, " count_hold"}, int'(bus.match_count), exp_count);
    endtask

    task automatic abort_run(input logic [7:0] d, input int k);
        int done_n = 0;
        int busy_n = 0;
        bus.start   = 1'b1;
        bus.data_in = d;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < k + 2; c++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort busy", int'(bus.busy), 0);
        check("abort det_resetn", int'(det_resetn), 1);
        check("abort partial", int'(bus.match_count), exp_hits(d, k));
        for (int c = 0; c < 12; c++) begin
            done_n += int'(bus.done);
            busy_n += int'(bus.busy);
            tick();
        end
        check("abort no_done", done_n, 0);
        check("abort stays_idle", busy_n, 0);
        check("abort count_kept", int'(bus.match_count), exp_hits(d, k));
        $display("abort data=%02h at_stream_cycle=%0d partial=%0d", d, k + 1, bus.match_count);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         hold;
        int         exp_count;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'hFF,        hold: 1'b0, exp_count: 5};
        vecs[1] = '{data: 8'b1101_1010, hold: 1'b0, exp_count: 2};
        vecs[2] = '{data: 8'h00,        hold: 1'b0, exp_count: 0};
        vecs[3] = '{data: 8'hDD,        hold: 1'b0, exp_count: 2};
        vecs[4] = '{data: 8'h0F,        hold: 1'b0, exp_count: 1};
        vecs[5] = '{data: 8'hFF,        hold: 1'b1, exp_count: 5};

        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.data_in = 8'h00;
        Resetn      = 1'b1;
        #1 Resetn   = 1'b0;
        #2;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset match_count", int'(bus.match_count), 0);
        check("reset w_out", int'(w_out), 0);
        check("reset det_resetn", int'(det_resetn), 1);
        tick();
        tick();
        @(negedge Clock);
        Resetn = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            full_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].hold, vecs[i].exp_count);
        end

        // Held start must not retrigger once the line is dropped back in IDLE.
        for (int c = 0; c < 5; c++) begin
            check("hold no_rerun", int'(bus.busy), 0);
            tick();
        end

        abort_run(8'hFF, 2);
        full_check("after_abort", 8'hFF, 1'b0, 5);
        abort_run(8'hFF, 6);
        abort_run(8'b1101_1010, 5);

        // Asynchronous reset in the middle of STREAM.
        bus.start   = 1'b1;
        bus.data_in = 8'hFF;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        check("pre_reset count", int'(bus.match_count), exp_hits(8'hFF, 5));
        check("pre_reset busy", int'(bus.busy), 1);
        #2 Resetn = 1'b0;
        #1;
        check("async busy", int'(bus.busy), 0);
        check("async match_count", int'(bus.match_count), 0);
        check("async w_out", int'(w_out), 0);
        check("async done", int'(bus.done), 0);
        check("async det_resetn", int'(det_resetn), 1);
        $display("async reset mid-stream busy=%0d count=%0d", bus.busy, bus.match_count);
        @(negedge Clock);
        Resetn = 1'b1;
        tick();
        full_check("after_reset", 8'hFF, 1'b0, 5);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            full_check($sformatf("rand%0d", i), d, 1'b0, exp_hits(d, 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
